avl_shim_fifo: RTL and testbench
================================

// Module: avl_shim_fifo
// PURPOSE
//  Parametrised NoC-to-Avalon-ST timing shim with an internal FIFO.
//  Absorbs up to READY_LATENCY in-flight beats after backpressure.
//  Presents a zero-latency valid/ready interface to the Avalon side.
//  Sits between the NoC translator output and the DDR3 frame-buffer Avalon master.
// PARAMETERS
//  WIDTH_PKT      546  packet payload width per beat (flit headers already stripped)
//  NUM_FLITS      4    width of the per-beat valid/sop/eop vectors
//  DEPTH          8    FIFO entries; power of 2, >= READY_LATENCY+2
//  READY_LATENCY  1    cycles from noc_ready_out to the upstream beat it permits; 0..DEPTH-2
// PORTS
//  clk            in   1             clock
//  rst_n          in   1             synchronous active-low reset
//  noc_data_in    in   WIDTH_PKT     beat payload from NoC
//  noc_valid_in   in   NUM_FLITS     per-flit valid; beat present when |noc_valid_in
//  noc_sop_in     in   NUM_FLITS     start-of-packet flags
//  noc_eop_in     in   NUM_FLITS     end-of-packet flags
//  noc_ready_out  out  1             permission for a beat READY_LATENCY cycles later
//  noc_data_out   out  WIDTH_PKT     head-of-FIFO payload
//  noc_valid_out  out  NUM_FLITS     head valid vector; all-zero when empty
//  noc_sop_out    out  NUM_FLITS     head sop vector
//  noc_eop_out    out  NUM_FLITS     head eop vector
//  noc_ready_in   in   1             Avalon sink ready (inverse of waitrequest), latency 0
//  occupancy      out  log2(DEPTH)+1 current entry count
//  overflow_err   out  1             sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): pointers=0, count=0, overflow_err=0, noc_valid_out=0,
//    noc_ready_out=1 after the reset edge. Reset mid-packet flushes all stored beats.
//  Push: any cycle with |noc_valid_in. Push is unconditional; ready is not re-checked here.
//    Stores {data,valid,sop,eop} at wr_ptr.
//  Pop: when count!=0 and noc_ready_in=1. Head advances at that posedge.
//  Output: noc_*_out driven from the head entry. noc_valid_out=0 when count==0.
//    Output is stable while noc_ready_in=0 (Avalon waitrequest hold).
//  Latency: a beat pushed at edge t appears at the output in cycle t+1. No bypass.
//  noc_ready_out = (count_q < DEPTH-READY_LATENCY), combinational from registered count.
//    Guarantees count<=DEPTH when all permitted beats arrive.
//  Simultaneous push+pop: count unchanged, including at count==DEPTH.
//  Pointer wrap: modulo DEPTH. count is a separate register of log2(DEPTH)+1 bits.
//  Full-throughput: with noc_ready_in held at 1, one beat per cycle is sustained indefinitely.
//  Overflow: push with count==DEPTH and no pop is a protocol violation
//    (upstream ignored noc_ready_out).
//  sop/eop are carried opaquely. The shim never reorders, splits or merges beats.
// CONFIGURATION
//  AVL_SHIM_OVF_CHECK_EN defined:
//    - overflowing push is dropped; FIFO contents and count are unchanged.
//    - overflow_err sets to 1 the next cycle and stays set until reset.
//  AVL_SHIM_OVF_CHECK_EN undefined:
//    - overflow_err tied to 0 and no check logic exists.
//    - overflowing write behaviour is undefined (overwrites the head).
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles with noc_valid_in=4'hF -> after release occupancy=0,
//    noc_valid_out=0, noc_ready_out=1.
//  2 Streaming: noc_ready_in=1, 20 beats with data=i, sop on beat 0, eop on beat 19 ->
//    identical sequence out, each 1 cycle later, occupancy<=1.
//  3 Backpressure: DEPTH=8, RL=1, noc_ready_in=0 while streaming ->
//    noc_ready_out falls when occupancy=7; final occupancy=8; no beat lost;
//    output holds beat 0 until noc_ready_in=1.
//  4 Push+pop at full: occupancy=8, valid in and noc_ready_in=1 same cycle ->
//    occupancy stays 8; order preserved.
//  5 Overflow (macro on): occupancy=8, noc_ready_in=0, force push ->
//    beat dropped; overflow_err=1 next cycle, sticky until rst_n=0.
//  6 Reset mid-packet: rst_n=0 with occupancy=5 after sop without eop ->
//    occupancy=0, next output beat is the first beat pushed after reset.

Source files
------------

// File: rtl/avl_shim_fifo.sv
`default_nettype none
// ============================================================================
// Module      : avl_shim_fifo
// Description : NoC-to-Avalon-ST timing shim. A small FIFO absorbs the beats
//               still in flight after noc_ready_out drops, and presents a
//               zero-latency valid/ready interface to the Avalon sink.
//               Optional build macro AVL_SHIM_OVF_CHECK_EN enables dropping
//               of overflowing pushes and a sticky overflow_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module avl_shim_fifo #(
  parameter int WIDTH_PKT     = 546,
  parameter int NUM_FLITS     = 4,
  parameter int DEPTH         = 8,
  parameter int READY_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH_PKT-1:0]   noc_data_in,
  input  logic [NUM_FLITS-1:0]   noc_valid_in,
  input  logic [NUM_FLITS-1:0]   noc_sop_in,
  input  logic [NUM_FLITS-1:0]   noc_eop_in,
  output logic                   noc_ready_out,
  output logic [WIDTH_PKT-1:0]   noc_data_out,
  output logic [NUM_FLITS-1:0]   noc_valid_out,
  output logic [NUM_FLITS-1:0]   noc_sop_out,
  output logic [NUM_FLITS-1:0]   noc_eop_out,
  input  logic                   noc_ready_in,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = WIDTH_PKT + 3 * NUM_FLITS;

  localparam logic [CNT_W-1:0] CNT_FULL        = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_READY_LIMIT = CNT_W'(DEPTH - READY_LATENCY);

  // Entry layout: {data, valid, sop, eop}
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             not_empty;

  assign push      = |noc_valid_in;
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && noc_ready_in;

`ifdef AVL_SHIM_OVF_CHECK_EN
  logic ovf_drop;
  logic ovf_q;

  // A push into a full FIFO with no simultaneous pop is discarded.
  assign ovf_drop = push && (count_q == CNT_FULL) && !pop;
  assign wr_en    = push && !ovf_drop;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ovf_drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow_err = ovf_q;
`else
  // Without the check an overflowing push lands on the head slot.
  assign wr_en        = push;
  assign overflow_err = 1'b0;
`endif

  // Payload storage; not reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {noc_data_in, noc_valid_in, noc_sop_in, noc_eop_in};
    end
  end

  // Pointer and entry-count bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head-of-FIFO presentation; flag vectors are forced low when empty.
  always_comb begin
    head          = mem[rd_ptr];
    noc_data_out  = head[ENT_W-1 -: WIDTH_PKT];
    noc_valid_out = '0;
    noc_sop_out   = '0;
    noc_eop_out   = '0;
    if (not_empty) begin
      noc_valid_out = head[3*NUM_FLITS-1 -: NUM_FLITS];
      noc_sop_out   = head[2*NUM_FLITS-1 -: NUM_FLITS];
      noc_eop_out   = head[NUM_FLITS-1 -: NUM_FLITS];
    end
  end

  // Leave room for READY_LATENCY beats that are already committed upstream.
  assign noc_ready_out = (count_q < CNT_READY_LIMIT);
  assign occupancy     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_avl_shim_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_avl_shim_fifo
// Description : Self-checking bench for avl_shim_fifo. A queue-based model
//               of the shim is stepped alongside the DUT and every output is
//               compared against it each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avl_shim_fifo;

  localparam int W     = 546;
  localparam int NF    = 4;
  localparam int DEPTH = 8;
  localparam int RL    = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  noc_data_in = '0;
  logic [NF-1:0] noc_valid_in = '0;
  logic [NF-1:0] noc_sop_in = '0;
  logic [NF-1:0] noc_eop_in = '0;
  logic          noc_ready_out;
  logic [W-1:0]  noc_data_out;
  logic [NF-1:0] noc_valid_out;
  logic [NF-1:0] noc_sop_out;
  logic [NF-1:0] noc_eop_out;
  logic          noc_ready_in = 1'b0;
  logic [CW-1:0] occupancy;
  logic          overflow_err;

  avl_shim_fifo #(
    .WIDTH_PKT    (W),
    .NUM_FLITS    (NF),
    .DEPTH        (DEPTH),
    .READY_LATENCY(RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .noc_data_in  (noc_data_in),
    .noc_valid_in (noc_valid_in),
    .noc_sop_in   (noc_sop_in),
    .noc_eop_in   (noc_eop_in),
    .noc_ready_out(noc_ready_out),
    .noc_data_out (noc_data_out),
    .noc_valid_out(noc_valid_out),
    .noc_sop_out  (noc_sop_out),
    .noc_eop_out  (noc_eop_out),
    .noc_ready_in (noc_ready_in),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [NF-1:0] v;
    logic [NF-1:0] s;
    logic [NF-1:0] e;
  } beat_t;

  beat_t q[$];          // model FIFO contents, head at index 0
  bit    m_ovf = 1'b0;  // model sticky overflow flag
  bit    perm_q[$];     // history of model ready for latency accounting
  bit    allow = 1'b0;  // upstream may send a beat this cycle
  bit    chk_en = 1'b0;
  int    tests_run = 0;
  int    tests_failed = 0;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    d = '0;
    repeat ((W + 31) / 32) d = (d << 32) | W'($urandom);
    return d;
  endfunction

  function automatic logic [NF-1:0] rnd_vec_nz();
    return NF'($urandom_range(1, (1 << NF) - 1));
  endfunction

  task automatic check_outputs();
    beat_t h;
    if (q.size() != 0) begin
      h = q[0];
      check("valid_out", W'(noc_valid_out), W'(h.v));
      check("data_out", noc_data_out, h.data);
      check("sop_out", W'(noc_sop_out), W'(h.s));
      check("eop_out", W'(noc_eop_out), W'(h.e));
    end else begin
      check("valid_out_empty", W'(noc_valid_out), '0);
    end
    check("occupancy", W'(occupancy), W'(q.size()));
    check("ready_out", W'(noc_ready_out), W'(q.size() < DEPTH - RL));
    check("overflow_err", W'(overflow_err), W'(m_ovf));
  endtask

  // Behavioural model: applied at the clock edge with the inputs the DUT saw.
  task automatic model_step();
    beat_t b;
    bit    do_push;
    bit    do_pop;
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      perm_q.delete();
    end else begin
      do_push = (noc_valid_in != '0);
      do_pop  = (q.size() != 0) && noc_ready_in;
      b = '{data: noc_data_in, v: noc_valid_in, s: noc_sop_in, e: noc_eop_in};
      if (do_push && q.size() == DEPTH && !do_pop) begin
`ifdef AVL_SHIM_OVF_CHECK_EN
        m_ovf = 1'b1;
`else
        q.push_back(b);
`endif
      end else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(b);
      end
    end
    perm_q.push_back(q.size() < DEPTH - RL);
    allow = (perm_q.size() > RL) ? perm_q.pop_front() : 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_en) check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input bit rst, input logic [NF-1:0] v, input logic [NF-1:0] s,
                      input logic [NF-1:0] e, input logic [W-1:0] d, input bit rdy);
    rst_n        = !rst;
    noc_valid_in = v;
    noc_sop_in   = s;
    noc_eop_in   = e;
    noc_data_in  = d;
    noc_ready_in = rdy;
    cycle();
  endtask

  task automatic idle(input bit rdy);
    send(1'b0, '0, '0, '0, rnd_data(), rdy);
  endtask

  initial begin
    int n;
    logic [W-1:0] first_after_rst;

    // 1: reset held for three edges with all flit valids asserted
    send(1'b1, 4'hF, '0, '0, rnd_data(), 1'b0);
    chk_en = 1'b1;
    send(1'b1, 4'hF, '0, '0, rnd_data(), 1'b0);
    send(1'b1, 4'hF, '0, '0, rnd_data(), 1'b0);
    check("rst_occupancy", W'(occupancy), '0);
    check("rst_valid_out", W'(noc_valid_out), '0);
    check("rst_ready_out", W'(noc_ready_out), W'(1));
    check("rst_overflow", W'(overflow_err), '0);

    // 2: full-rate streaming of a 20-beat packet
    for (int i = 0; i < 20; i++) begin
      send(1'b0, rnd_vec_nz(), NF'(i == 0), NF'(i == 19), W'(i), 1'b1);
      check("stream_occ_le1", W'(occupancy <= 1), W'(1));
    end
    idle(1'b1);
    idle(1'b1);

    // 3: backpressure, upstream honours ready with latency RL
    n = 0;
    for (int c = 0; c < 16; c++) begin
      if (allow) begin
        send(1'b0, rnd_vec_nz(), NF'(n == 0), '0, W'(100 + n), 1'b0);
        n++;
      end else begin
        idle(1'b0);
      end
    end
    check("bp_full_occ", W'(occupancy), W'(DEPTH));
    check("bp_head_held", noc_data_out, W'(100));
    check("bp_ready_low", W'(noc_ready_out), '0);

    // 4: simultaneous push and pop while full
    send(1'b0, rnd_vec_nz(), '0, 4'h1, W'(200), 1'b1);
    check("full_pushpop_occ", W'(occupancy), W'(DEPTH));
    check("full_pushpop_head", noc_data_out, W'(101));

`ifdef AVL_SHIM_OVF_CHECK_EN
    // 5: forced push into a full FIFO is dropped and flagged stickily
    send(1'b0, rnd_vec_nz(), '0, '0, W'(300), 1'b0);
    check("ovf_flag", W'(overflow_err), W'(1));
    check("ovf_occ", W'(occupancy), W'(DEPTH));
    idle(1'b1);
    idle(1'b0);
    check("ovf_sticky", W'(overflow_err), W'(1));
`endif

    // drain
    for (int c = 0; c < DEPTH + 2; c++) idle(1'b1);
    check("drained", W'(occupancy), '0);

    // 6: reset in the middle of a packet flushes stored beats
    for (int i = 0; i < 5; i++) begin
      send(1'b0, rnd_vec_nz(), NF'(i == 0), '0, W'(400 + i), 1'b0);
    end
    check("mid_occ5", W'(occupancy), W'(5));
    send(1'b1, rnd_vec_nz(), '0, '0, rnd_data(), 1'b0);
    check("mid_rst_occ", W'(occupancy), '0);
    check("mid_rst_ovf", W'(overflow_err), '0);
    first_after_rst = rnd_data();
    send(1'b0, 4'h1, 4'h1, '0, first_after_rst, 1'b0);
    check("mid_rst_next_beat", noc_data_out, first_after_rst);
    idle(1'b1);

    // randomized traffic honouring the ready protocol
    for (int c = 0; c < 400; c++) begin
      if (allow && ($urandom_range(0, 3) != 0)) begin
        send(1'b0, rnd_vec_nz(), NF'($urandom), NF'($urandom), rnd_data(), ($urandom_range(0, 2) != 0));
      end else begin
        idle($urandom_range(0, 2) != 0);
      end
    end
    for (int c = 0; c < DEPTH + 2; c++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
